arb_grant_lock: RTL and testbench
=================================

# arb_grant_lock

Registered ownership-lock stage that sits directly downstream of the 4-way fixed-priority arbiter. It samples the arbiter's combinational one-hot grant and latches it into a held owner, keeping that owner stable for a whole transaction. Ownership ends on the owner's done pulse, on the owner dropping its request, or on a hold timeout. Downstream mux and select logic use `owner`/`owner_idx` instead of the raw, glitch-prone arbiter grant.

## Interface
Parameters:
- `N`, 4, number of requesters; must match the arbiter width.
- `IDX_W`, 2, width of `owner_idx`; equals $clog2(N).
- `TIMEOUT`, 16, maximum cycles an owner may hold the lock; must be ≥2.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `req`  input  N  raw request vector, the same vector that drives the arbiter.
- `grant_in`  input  N  one-hot grant from the fixed-priority arbiter; bit N-1 has highest priority.
- `done`  input  N  per-requester transaction-complete pulse.
- `owner`  output  N  registered one-hot current owner; all zeros when no owner.
- `owner_idx`  output  IDX_W  binary index of the owner; 0 when no owner.
- `busy`  output  1  high while in LOCKED.
- `grant_pulse`  output  1  one-cycle pulse on the first cycle of each new lock.
- `timeout_err`  output  1  one-cycle pulse when a lock is force-released by timeout.
- `protocol_err`  output  1  one-cycle pulse when `grant_in` has more than one bit set while sampled in IDLE.

## Operation
- Reset, applied asynchronously at any time including mid-lock, forces the following immediately:
  - state IDLE;
  - `owner`, `owner_idx`, `busy`, `grant_pulse`, `timeout_err`, `protocol_err` and the hold counter all to 0.
- FSM states are IDLE, LOCKED and RELEASE.
- IDLE:
  - `grant_in` exactly one-hot: go to LOCKED, `owner`<=`grant_in`, `owner_idx`<=encoded index, counter<=0, `grant_pulse`<=1.
  - `grant_in` zero: stay in IDLE.
  - `grant_in` multi-hot: stay in IDLE and pulse `protocol_err`. No lock is taken.
- LOCKED:
  - `owner` and `owner_idx` are frozen. Changes on `grant_in` are ignored.
  - The counter increments each cycle.
  - Release condition, evaluated each cycle: `done[owner_idx]`=1, OR `req[owner_idx]`=0, OR counter==TIMEOUT-1.
  - On release, go to RELEASE and clear `owner`, `owner_idx` and `busy` at that edge.
  - `timeout_err` pulses only when the timeout is the sole cause. If done or a request drop coincides with the timeout, it is a normal release with no error.
  - `done` bits of non-owners are ignored in every state.
- RELEASE: one mandatory dead cycle with no sampling, then IDLE. This gives the arbiter a settled cycle before the next lock.
- Counter width is $clog2(TIMEOUT). It never wraps, because it only runs in LOCKED and is cleared on lock.

## Timing
- Lock latency: `grant_in` valid at edge k (in IDLE) → `owner`, `owner_idx`, `busy` and `grant_pulse` high after edge k.
- `grant_pulse` is low after edge k+1 while still LOCKED.
- Release at edge r → `owner` = 0 after r; state RELEASE after r; IDLE after r+1.
- The earliest next lock is sampled at edge r+2. Owner is therefore low for exactly 2 cycles between back-to-back locks.
- Maximum hold: with no done and request held, `owner` is high for exactly TIMEOUT cycles. `timeout_err` is high in the first cycle after release.
- `done` in the same cycle as the lock edge (state still IDLE) is ignored.
- The earliest done-release is at the lock edge +1, giving a minimum hold of 1 cycle.
- All outputs are registered. There are no combinational input→output paths.

## Test plan
- Reset/idle: assert `rst` mid-LOCKED (owner=0100) → all outputs 0 immediately (asynchronously), state IDLE; with `req`/`grant_in`=0000 after reset, outputs stay 0.
- Basic lock/done:
  - Stimulus: `req`=0011, `grant_in`=0010 at edge 1; `done`=0010 at edge 4.
  - Response: `owner`=0010, `owner_idx`=1 and `grant_pulse` after edge 1; `owner`=0000 after edge 4.
  - Next lock, with `req`=0001, `grant_in`=0001, appears after edge 6.
- Preemption blocked: while owner=0001, raise `req` to 1111 with `grant_in`=1000 → owner stays 0001 until `done`[0]. Then owner=1000 two edges later.
- Timeout: TIMEOUT=16, `req`=0100 held, no done → `owner`=0100 for exactly 16 cycles, then `timeout_err`=1 for one cycle, then a 2-cycle gap, then a re-lock to 0100.
- Coincident events: `done`[2] asserted on the same edge the counter reaches 15 → release with `timeout_err`=0. A non-owner `done`=1000 during the lock has no effect.
- Request drop and bad grant:
  - Owner 0010 drops `req`[1] → released at that edge, no error.
  - In IDLE, `grant_in`=0110 → `protocol_err` pulses once, owner stays 0000.

Source files
------------

// File: rtl/arb_grant_lock.sv
// Ownership-lock stage behind the fixed-priority arbiter: latches a one-hot
// grant into a held owner until done, request drop or hold timeout.
module arb_grant_lock #(
    parameter int N       = 4,
    parameter int IDX_W   = 2,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     grant_in,
    input  logic [N-1:0]     done,
    output logic [N-1:0]     owner,
    output logic [IDX_W-1:0] owner_idx,
    output logic             busy,
    output logic             grant_pulse,
    output logic             timeout_err,
    output logic             protocol_err,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOCKED  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             gpulse_q, gpulse_d;
    logic             terr_q, terr_d;
    logic             perr_q, perr_d;

    logic             grant_any;
    logic             grant_multi;
    logic [IDX_W-1:0] grant_enc;
    logic             own_done;
    logic             own_req;
    logic             at_limit;

    // Clearing the lowest set bit leaves a residue only when two or more bits are set.
    assign grant_any   = |grant_in;
    assign grant_multi = |(grant_in & (grant_in - N'(1)));

    always_comb begin
        grant_enc = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_in[i]) grant_enc = IDX_W'(i);
        end
    end

    assign own_done = done[idx_q];
    assign own_req  = req[idx_q];
    assign at_limit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        gpulse_d = 1'b0;
        terr_d   = 1'b0;
        perr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_any && grant_multi) begin
                    perr_d = 1'b1;
                end else if (grant_any) begin
                    state_d  = LOCKED;
                    owner_d  = grant_in;
                    idx_d    = grant_enc;
                    cnt_d    = '0;
                    busy_d   = 1'b1;
                    gpulse_d = 1'b1;
                end
            end
            LOCKED: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (own_done || !own_req || at_limit) begin
                    state_d = RELEASE;
                    owner_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                    // Error only when the timeout alone forced the release.
                    terr_d  = at_limit && !own_done && own_req;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                owner_d = '0;
                idx_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            gpulse_q <= 1'b0;
            terr_q   <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            gpulse_q <= gpulse_d;
            terr_q   <= terr_d;
            perr_q   <= perr_d;
        end
    end

    assign owner        = owner_q;
    assign owner_idx    = idx_q;
    assign busy         = busy_q;
    assign grant_pulse  = gpulse_q;
    assign timeout_err  = terr_q;
    assign protocol_err = perr_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_arb_grant_lock.sv
// Bench for arb_grant_lock: directed scenarios plus random traffic, all
// compared against an ownership model kept in plain integers.
module tb_arb_grant_lock;

    localparam int N       = 4;
    localparam int IDX_W   = 2;
    localparam int TIMEOUT = 16;

    logic             clk;
    logic             rst;
    logic [N-1:0]     req;
    logic [N-1:0]     grant_in;
    logic [N-1:0]     done;
    logic [N-1:0]     owner;
    logic [IDX_W-1:0] owner_idx;
    logic             busy;
    logic             grant_pulse;
    logic             timeout_err;
    logic             protocol_err;
    logic [1:0]       dbg_state;

    int errors = 0;
    int checks = 0;

    // Model: who owns (-1 = nobody), edges held so far, dead cycles left.
    int m_owner;
    int m_held;
    int m_dead;
    logic m_gpulse, m_terr, m_perr;

    arb_grant_lock #(.N(N), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant_in     (grant_in),
        .done         (done),
        .owner        (owner),
        .owner_idx    (owner_idx),
        .busy         (busy),
        .grant_pulse  (grant_pulse),
        .timeout_err  (timeout_err),
        .protocol_err (protocol_err),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_held   = 0;
        m_dead   = 0;
        m_gpulse = 1'b0;
        m_terr   = 1'b0;
        m_perr   = 1'b0;
    endtask

    task automatic model_edge();
        m_gpulse = 1'b0;
        m_terr   = 1'b0;
        m_perr   = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (done[m_owner] || !req[m_owner] || m_held == TIMEOUT) begin
                m_terr  = (m_held == TIMEOUT) && !done[m_owner] && req[m_owner];
                m_owner = -1;
                m_dead  = 1;
            end
        end else if (m_dead > 0) begin
            m_dead--;
        end else if ($countones(grant_in) == 1) begin
            for (int i = 0; i < N; i++) if (grant_in[i]) m_owner = i;
            m_held   = 0;
            m_gpulse = 1'b1;
        end else if ($countones(grant_in) > 1) begin
            m_perr = 1'b1;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_owner;
        logic [IDX_W-1:0] exp_idx;
        exp_owner = '0;
        exp_idx   = '0;
        if (m_owner >= 0) begin
            exp_owner[m_owner] = 1'b1;
            exp_idx = IDX_W'(m_owner);
        end
        chk("owner", 32'(owner), 32'(exp_owner));
        chk("owner_idx", 32'(owner_idx), 32'(exp_idx));
        chk("busy", 32'(busy), 32'(m_owner >= 0));
        chk("grant_pulse", 32'(grant_pulse), 32'(m_gpulse));
        chk("timeout_err", 32'(timeout_err), 32'(m_terr));
        chk("protocol_err", 32'(protocol_err), 32'(m_perr));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] g, input logic [N-1:0] d);
        req      = r;
        grant_in = g;
        done     = d;
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step('0, '0, '0);
    endtask

    function automatic logic [N-1:0] prio_grant(input logic [N-1:0] r);
        logic [N-1:0] g;
        g = '0;
        for (int i = 0; i < N; i++) if (r[i]) g = '0 | (N'(1) << i);
        return g;
    endfunction

    initial begin
        int hold_len;
        logic [N-1:0] r_rand, g_rand, d_rand;
        rst = 1'b1;
        req = '0; grant_in = '0; done = '0;
        model_reset();
        #12;
        check_outputs();
        chk("reset_state", 32'(dbg_state), 32'd0);
        #4 rst = 1'b0;
        idle_steps(3);

        // Basic lock, release on done, re-lock after the dead cycle.
        step(4'b0011, 4'b0010, 4'b0000);
        step(4'b0011, 4'b0000, 4'b0000);
        step(4'b0011, 4'b0000, 4'b0000);
        step(4'b0011, 4'b0000, 4'b0010);
        step(4'b0001, 4'b0001, 4'b0000);
        step(4'b0001, 4'b0001, 4'b0000);
        chk("relock_owner", 32'(owner), 32'h1);

        // Preemption attempt while 0001 owns.
        for (int i = 0; i < 3; i++) step(4'b1111, 4'b1000, 4'b0000);
        step(4'b1111, 4'b1000, 4'b0001);
        step(4'b1111, 4'b1000, 4'b0000);
        step(4'b1111, 4'b1000, 4'b0000);
        chk("preempt_owner", 32'(owner), 32'h8);
        step(4'b0000, 4'b0000, 4'b0000);
        idle_steps(2);

        // Timeout: hold length measured on the bus itself.
        step(4'b0100, 4'b0100, 4'b0000);
        hold_len = 1;
        for (int i = 0; i < 40 && owner == 4'b0100; i++) begin
            step(4'b0100, 4'b0100, 4'b0000);
            if (owner == 4'b0100) hold_len++;
        end
        chk("hold_len", 32'(hold_len), 32'(TIMEOUT));
        chk("timeout_pulse", 32'(timeout_err), 32'd1);
        step(4'b0100, 4'b0100, 4'b0000);
        step(4'b0100, 4'b0100, 4'b0000);
        chk("timeout_relock", 32'(owner), 32'h4);

        // Owner done coinciding with the last allowed cycle; non-owner done ignored.
        step(4'b0000, 4'b0000, 4'b0000);
        idle_steps(2);
        step(4'b0100, 4'b0100, 4'b0000);
        for (int i = 1; i < TIMEOUT; i++) step(4'b0100, 4'b0000, (i == 3) ? 4'b1000 : 4'b0000);
        chk("coincide_held", 32'(owner), 32'h4);
        step(4'b0100, 4'b0000, 4'b0100);
        chk("coincide_noerr", 32'(timeout_err), 32'd0);
        idle_steps(2);

        // Request drop, then a multi-hot grant in IDLE.
        step(4'b0010, 4'b0010, 4'b0000);
        step(4'b0010, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000);
        idle_steps(1);
        step(4'b0110, 4'b0110, 4'b0000);
        chk("perr_pulse", 32'(protocol_err), 32'd1);
        step(4'b0000, 4'b0000, 4'b0000);

        // Asynchronous reset in the middle of a lock.
        step(4'b0100, 4'b0100, 4'b0000);
        step(4'b0100, 4'b0000, 4'b0000);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        chk("midlock_reset_state", 32'(dbg_state), 32'd0);
        #2 rst = 1'b0;
        idle_steps(3);

        // Random traffic.
        r_rand = '0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 5) == 0) r_rand = N'($urandom_range(0, (1 << N) - 1));
            g_rand = prio_grant(r_rand);
            if ($urandom_range(0, 9) == 0) g_rand = N'($urandom_range(0, (1 << N) - 1));
            d_rand = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, (1 << N) - 1)) : '0;
            step(r_rand, g_rand, d_rand);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
